// File: rtl/csr_sequencer_pkg.sv
// Shared types for the Zicsr issue sequencer.
// funct3 codes, csrfile opcodes, FSM states and operand helpers.
package biriq_csr_pkg;

    localparam int CSR_ADDR_W = 12;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HEAD,
        S_ISSUE,
        S_WAIT_DONE,
        S_WB
    } seq_state_e;

    // Set/clear forms with x0 / zimm=0 only read the CSR.
    function automatic logic csr_wr_intent(
        input logic [2:0] f3,
        input logic [4:0] idx
    );
        return (f3[1:0] == CSR_OP_RW) || (idx != 5'd0);
    endfunction

    // Immediate forms use the rs1 field as a zero-extended zimm.
    function automatic logic [31:0] csr_operand(
        input logic [2:0]  f3,
        input logic [31:0] rs1_data,
        input logic [4:0]  idx
    );
        return f3[2] ? {27'd0, idx} : rs1_data;
    endfunction

endpackage

// File: rtl/csr_sequencer.sv
// Issue-side sequencer for Zicsr ops: waits for ROB head, fires one
// csrfile request, collects the old value and returns a writeback.
module csr_sequencer
    import biriq_csr_pkg::*;
#(
    parameter int ROB_W = 6,
    parameter int REG_W = 6
) (
    input  logic                  cpu_clock_i,
    input  logic                  cpu_reset_n_i,
    input  logic                  uop_valid_i,
    output logic                  uop_ready_o,
    input  logic [2:0]            uop_funct3_i,
    input  logic [CSR_ADDR_W-1:0] uop_csr_i,
    input  logic [31:0]           uop_rs1_data_i,
    input  logic [4:0]            uop_rs1_idx_i,
    input  logic [REG_W-1:0]      uop_prd_i,
    input  logic [ROB_W-1:0]      uop_rob_i,
    input  logic [ROB_W-1:0]      rob_head_i,
    input  logic                  flush_i,
    output logic [31:0]           csr_data_o,
    output logic [CSR_ADDR_W-1:0] csr_addr_o,
    output logic [1:0]            csr_opcode_o,
    output logic                  csr_wr_en_o,
    output logic                  csr_valid_o,
    input  logic                  csr_done_i,
    input  logic                  csr_excp_i,
    input  logic [31:0]           csr_rdata_i,
    output logic                  wb_valid_o,
    output logic [REG_W-1:0]      wb_prd_o,
    output logic [31:0]           wb_data_o,
    output logic [ROB_W-1:0]      wb_rob_o,
    output logic                  wb_excp_o
);

    seq_state_e            r_state;
    logic                  r_ready;
    logic                  r_csr_valid;
    logic                  r_wb_valid;
    logic                  r_squash;
    logic [31:0]           r_data;
    logic [CSR_ADDR_W-1:0] r_addr;
    csr_op_e               r_op;
    logic                  r_wr_en;
    logic [REG_W-1:0]      r_prd;
    logic [ROB_W-1:0]      r_rob;
    logic [31:0]           r_wb_data;
    logic                  r_wb_excp;

    logic                  w_head_hit;
    logic                  w_kill;

    assign w_head_hit = (r_rob == rob_head_i);
    assign w_kill     = r_squash | flush_i;

    assign uop_ready_o  = r_ready;
    assign csr_valid_o  = r_csr_valid;
    assign csr_data_o   = r_data;
    assign csr_addr_o   = r_addr;
    assign csr_opcode_o = r_op;
    assign csr_wr_en_o  = r_wr_en;
    // A flush landing in the WB cycle itself still cancels the writeback.
    assign wb_valid_o   = r_wb_valid & ~flush_i;
    assign wb_prd_o     = r_prd;
    assign wb_rob_o     = r_rob;
    assign wb_data_o    = r_wb_data;
    assign wb_excp_o    = r_wb_excp;

    // Sequencer FSM with registered request/writeback outputs.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_csr_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_squash    <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
            r_op        <= CSR_OP_NONE;
            r_wr_en     <= 1'b0;
            r_prd       <= '0;
            r_rob       <= '0;
            r_wb_data   <= '0;
            r_wb_excp   <= 1'b0;
        end else begin
            r_csr_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (uop_valid_i && !flush_i) begin
                        r_data   <= csr_operand(uop_funct3_i,
                                                uop_rs1_data_i,
                                                uop_rs1_idx_i);
                        r_addr   <= uop_csr_i;
                        r_op     <= csr_op_e'(uop_funct3_i[1:0]);
                        r_wr_en  <= csr_wr_intent(uop_funct3_i,
                                                  uop_rs1_idx_i);
                        r_prd    <= uop_prd_i;
                        r_rob    <= uop_rob_i;
                        r_squash <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= S_WAIT_HEAD;
                    end
                end
                S_WAIT_HEAD: begin
                    if (flush_i) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_head_hit) begin
                        r_csr_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (flush_i) begin
                        r_squash <= 1'b1;
                    end
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (csr_done_i) begin
                        r_wb_excp <= csr_excp_i;
                        r_wb_data <= csr_excp_i ? 32'd0 : csr_rdata_i;
                        if (w_kill) begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_state    <= S_WB;
                        end
                    end else if (flush_i) begin
                        r_squash <= 1'b1;
                    end
                end
                S_WB: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_sequencer.sv
// Randomized bench for csr_sequencer against a transaction-level model
// of the ROB head, flush timing and a small CSR register file.
module tb_csr_sequencer;
    import biriq_csr_pkg::*;

    localparam int ROB_W = 6;
    localparam int REG_W = 6;

    logic             clk;
    logic             rst_n;
    logic             uop_valid;
    logic             uop_ready;
    logic [2:0]       uop_funct3;
    logic [11:0]      uop_csr;
    logic [31:0]      uop_rs1_data;
    logic [4:0]       uop_rs1_idx;
    logic [REG_W-1:0] uop_prd;
    logic [ROB_W-1:0] uop_rob;
    logic [ROB_W-1:0] rob_head;
    logic             flush;
    logic [31:0]      csr_data;
    logic [11:0]      csr_addr;
    logic [1:0]       csr_opcode;
    logic             csr_wr_en;
    logic             csr_valid;
    logic             csr_done;
    logic             csr_excp;
    logic [31:0]      csr_rdata;
    logic             wb_valid;
    logic [REG_W-1:0] wb_prd;
    logic [31:0]      wb_data;
    logic [ROB_W-1:0] wb_rob;
    logic             wb_excp;

    csr_sequencer #(.ROB_W(ROB_W), .REG_W(REG_W)) dut (
        .cpu_clock_i    (clk),
        .cpu_reset_n_i  (rst_n),
        .uop_valid_i    (uop_valid),
        .uop_ready_o    (uop_ready),
        .uop_funct3_i   (uop_funct3),
        .uop_csr_i      (uop_csr),
        .uop_rs1_data_i (uop_rs1_data),
        .uop_rs1_idx_i  (uop_rs1_idx),
        .uop_prd_i      (uop_prd),
        .uop_rob_i      (uop_rob),
        .rob_head_i     (rob_head),
        .flush_i        (flush),
        .csr_data_o     (csr_data),
        .csr_addr_o     (csr_addr),
        .csr_opcode_o   (csr_opcode),
        .csr_wr_en_o    (csr_wr_en),
        .csr_valid_o    (csr_valid),
        .csr_done_i     (csr_done),
        .csr_excp_i     (csr_excp),
        .csr_rdata_i    (csr_rdata),
        .wb_valid_o     (wb_valid),
        .wb_prd_o       (wb_prd),
        .wb_data_o      (wb_data),
        .wb_rob_o       (wb_rob),
        .wb_excp_o      (wb_excp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] csr_tab [4];
    logic [31:0] csr_mem [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(uop_ready), 32'd1);
        chk({tag, "_cvalid"},  32'(csr_valid), 32'd0);
        chk({tag, "_wbvalid"}, 32'(wb_valid),  32'd0);
        chk({tag, "_wbexcp"},  32'(wb_excp),   32'd0);
        chk({tag, "_cdata"},   csr_data,       32'd0);
        chk({tag, "_caddr"},   32'(csr_addr),  32'd0);
        chk({tag, "_cop"},     32'(csr_opcode), 32'd0);
        chk({tag, "_cwe"},     32'(csr_wr_en), 32'd0);
        chk({tag, "_wbdata"},  wb_data,        32'd0);
        chk({tag, "_wbrob"},   32'(wb_rob),    32'd0);
        chk({tag, "_wbprd"},   32'(wb_prd),    32'd0);
    endtask

    // One transaction. hd: cycle from which ROB head matches (0 = already
    // head at accept). dd: csrfile done delay after the request. fl: cycle
    // of a one-cycle flush (0 = none). Cycles count from the accept edge.
    task automatic run_op(input logic [2:0] f3, input int ai,
                          input logic [31:0] rs1d, input logic [4:0] idx,
                          input int hd, input int dd, input logic ex,
                          input int fl);
        logic [ROB_W-1:0] tag;
        logic [REG_W-1:0] prd;
        logic [31:0] exp_data;
        logic [31:0] old_val;
        logic [31:0] new_val;
        logic        exp_we;
        logic        wr_form;
        int          p_cyc;
        int          issued;
        int          wb_exp;
        int          pulses;
        int          wbs;
        int          pc;
        bit          seen_ready;

        tag = ROB_W'($urandom);
        prd = REG_W'($urandom);
        exp_data = f3[2] ? {27'd0, idx} : rs1d;
        wr_form = (f3 == 3'b001) || (f3 == 3'b101);
        exp_we = wr_form || (idx != 5'd0);
        p_cyc = (hd == 0) ? 2 : hd + 1;
        issued = (fl != 0 && fl < p_cyc) ? 0 : 1;
        wb_exp = (issued == 1 && !(fl != 0 && fl <= p_cyc + dd + 1)) ? 1 : 0;
        old_val = csr_mem[ai];
        pulses = 0;
        wbs = 0;
        pc = 0;

        seen_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (uop_ready) begin
                seen_ready = 1;
                break;
            end
        end
        chk("ready_before_accept", 32'(seen_ready), 32'd1);

        uop_valid    = 1'b1;
        uop_funct3   = f3;
        uop_csr      = csr_tab[ai];
        uop_rs1_data = rs1d;
        uop_rs1_idx  = idx;
        uop_prd      = prd;
        uop_rob      = tag;
        rob_head     = (hd == 0) ? tag : tag + ROB_W'(1);
        flush        = 1'b0;

        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            uop_valid    = 1'b0;
            uop_rs1_data = $urandom;
            if (hd != 0 && cyc >= hd) rob_head = tag;
            flush = (fl != 0 && cyc == fl);
            if (pc != 0 && cyc == pc + dd) begin
                csr_done  = 1'b1;
                csr_excp  = ex;
                csr_rdata = old_val;
            end else begin
                csr_done  = 1'b0;
                csr_excp  = 1'b0;
                csr_rdata = $urandom;
            end
            #1;
            if (csr_valid) begin
                pulses++;
                pc = cyc;
                chk("issue_cycle", 32'(cyc), 32'(p_cyc));
                chk("req_addr", 32'(csr_addr), 32'(csr_tab[ai]));
                chk("req_data", csr_data, exp_data);
                chk("req_opcode", 32'(csr_opcode), 32'(f3[1:0]));
                chk("req_wr_en", 32'(csr_wr_en), 32'(exp_we));
                if (!ex && exp_we) begin
                    case (f3[1:0])
                        2'b01:   new_val = exp_data;
                        2'b10:   new_val = old_val | exp_data;
                        default: new_val = old_val & ~exp_data;
                    endcase
                    csr_mem[ai] = new_val;
                end
            end
            if (wb_valid) begin
                wbs++;
                chk("wb_cycle", 32'(cyc), 32'(p_cyc + dd + 1));
                chk("wb_data", wb_data, ex ? 32'd0 : old_val);
                chk("wb_excp", 32'(wb_excp), 32'(ex));
                chk("wb_prd", 32'(wb_prd), 32'(prd));
                chk("wb_rob", 32'(wb_rob), 32'(tag));
                chk("wb_not_ready", 32'(uop_ready), 32'd0);
            end
        end
        flush    = 1'b0;
        csr_done = 1'b0;
        csr_excp = 1'b0;
        chk("n_issue", 32'(pulses), 32'(issued));
        chk("n_wb", 32'(wbs), 32'(wb_exp));
        chk("ready_after", 32'(uop_ready), 32'd1);
    endtask

    task automatic reset_mid_op();
        int pulses;
        logic [ROB_W-1:0] tag;
        tag = ROB_W'($urandom);
        @(negedge clk);
        uop_valid    = 1'b1;
        uop_funct3   = 3'b001;
        uop_csr      = 12'h340;
        uop_rs1_data = 32'hA5A5_A5A5;
        uop_rs1_idx  = 5'd3;
        uop_prd      = 6'd9;
        uop_rob      = tag;
        rob_head     = tag + ROB_W'(1);
        @(negedge clk);
        uop_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        rob_head = tag;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (csr_valid) pulses++;
        end
        chk("midrst_no_issue", 32'(pulses), 32'd0);
    endtask

    logic [2:0] f3_tab [6];

    initial begin
        int ai;
        int hd;
        int dd;
        int fl;
        logic [4:0] idx;
        logic [2:0] f3;

        csr_tab = '{12'h340, 12'hB00, 12'h300, 12'h305};
        csr_mem = '{32'h1234_5678, 32'h0000_0F00, 32'h0000_1800, 32'h8000_0000};
        f3_tab  = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

        rst_n        = 1'b0;
        uop_valid    = 1'b0;
        uop_funct3   = 3'b000;
        uop_csr      = 12'h000;
        uop_rs1_data = 32'd0;
        uop_rs1_idx  = 5'd0;
        uop_prd      = '0;
        uop_rob      = '0;
        rob_head     = '0;
        flush        = 1'b0;
        csr_done     = 1'b0;
        csr_excp     = 1'b0;
        csr_rdata    = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b001, 0, 32'hDEAD_BEEF, 5'd1, 0, 1, 1'b0, 0);
        run_op(3'b010, 1, 32'hFFFF_FFFF, 5'd0, 0, 1, 1'b0, 0);
        run_op(3'b111, 0, 32'hFFFF_FFFF, 5'd5, 0, 2, 1'b0, 0);
        run_op(3'b001, 3, 32'h0000_1234, 5'd7, 10, 1, 1'b0, 0);
        run_op(3'b001, 3, 32'h0000_5678, 5'd7, 6, 1, 1'b0, 3);
        run_op(3'b001, 2, 32'h0000_0008, 5'd2, 0, 1, 1'b1, 0);
        run_op(3'b011, 0, 32'h0000_00FF, 5'd4, 0, 3, 1'b0, 3);
        run_op(3'b110, 1, 32'h0, 5'd9, 0, 1, 1'b0, 4);

        reset_mid_op();

        for (int n = 0; n < 80; n++) begin
            f3  = f3_tab[$urandom_range(0, 5)];
            ai  = $urandom_range(0, 3);
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            hd  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
            dd  = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0) begin
                fl = $urandom_range(1, ((hd == 0) ? 2 : hd + 1) + dd + 2);
            end else begin
                fl = 0;
            end
            run_op(f3, ai, $urandom, idx, hd, dd,
                   ($urandom_range(0, 4) == 0), fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_sequencer.md
# csr_sequencer

Issue-side sequencer for Zicsr instructions, upstream of the CSR file. Accepts one CSR micro-op from the integer issue queue, holds it until it is the oldest uncommitted instruction, drives a single-cycle request into the CSR file, collects the registered read data and exception flag, and returns a writeback packet to the register file and ROB. Only one CSR op is in flight at a time; the block is the sole driver of the CSR file request port.

## Interface
- ROB_W, 6, width of ROB tag
- REG_W, 6, physical destination register index width
- cpu_clock_i  in  1  core clock
- cpu_reset_n_i  in  1  asynchronous active-low reset
- uop_valid_i  in  1  CSR micro-op offered
- uop_ready_o  out  1  sequencer can accept (IDLE)
- uop_funct3_i  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- uop_csr_i  in  12  CSR address
- uop_rs1_data_i  in  32  rs1 operand (ignored for immediate forms)
- uop_rs1_idx_i  in  5  architectural rs1 / zimm field
- uop_prd_i  in  REG_W  physical destination
- uop_rob_i  in  ROB_W  ROB tag
- rob_head_i  in  ROB_W  tag of oldest uncommitted instruction
- flush_i  in  1  pipeline flush (mispredict/exception/mret)
- csr_data_o  out  32  to csrfile data input
- csr_addr_o  out  12  to csrfile address
- csr_opcode_o  out  2  01 RW, 10 RS, 11 RC
- csr_wr_en_o  out  1  write intent
- csr_valid_o  out  1  one-cycle request strobe
- csr_done_i  in  1  csrfile completion
- csr_excp_i  in  1  csrfile illegal-access flag
- csr_rdata_i  in  32  csrfile read data
- wb_valid_o  out  1  writeback strobe
- wb_prd_o  out  REG_W  destination
- wb_data_o  out  32  old CSR value
- wb_rob_o  out  ROB_W  ROB tag
- wb_excp_o  out  1  raise illegal-instruction at ROB

## Operation
- States: IDLE, WAIT_HEAD, ISSUE, WAIT_DONE, WB.
- IDLE: uop_ready_o=1. On uop_valid_i & !flush_i latch all uop fields, -> WAIT_HEAD.
- WAIT_HEAD: when latched rob == rob_head_i -> ISSUE. flush_i -> IDLE, nothing sent.
- ISSUE: csr_valid_o=1 for exactly this cycle -> WAIT_DONE.
- WAIT_DONE: on csr_done_i capture csr_rdata_i and csr_excp_i -> WB.
- WB: wb_valid_o=1 one cycle -> IDLE.
- flush_i in ISSUE/WAIT_DONE/WB: request is already committed to csrfile; complete the done handshake but suppress wb_valid_o, then IDLE.
- Operand: funct3[2]=0 -> csr_data_o = rs1_data; funct3[2]=1 -> csr_data_o = {27'd0, zimm}.
- csr_opcode_o = funct3[1:0].
- csr_wr_en_o = 1 for RW/RWI; for RS/RC/RSI/RCI = (rs1_idx != 0).
- wb_excp_o = captured csr_excp_i; wb_data_o forced to 0 when excp.
- csr_data_o/addr/opcode/wr_en held stable from WAIT_HEAD entry until IDLE.

## Timing
- Reset: state IDLE; uop_ready_o=1; csr_valid_o, wb_valid_o, wb_excp_o = 0; all data/addr/tag outputs 0.
- Minimum latency accept -> wb_valid_o: 4 cycles when already head (WAIT_HEAD 1, ISSUE 1, WAIT_DONE 1 with csrfile done next cycle, WB 1).
- csr_done_i arriving in ISSUE cycle is illegal; ignore it.
- No new uop accepted in the WB cycle; next accept earliest the cycle after WB.
- Reset asserted mid-op aborts immediately; no csr_valid_o pulse after reset release until a new uop.

## Structure
- Package biriq_csr_pkg: funct3 codes, csrfile opcode enum (RW=01, RS=10, RC=11), sequencer state enum, CSR_ADDR_W=12.
- Single module; no sub-module warranted.

## Test plan
- CSRRW mscratch, rs1_data=0xDEADBEEF, tag already head -> one csr_valid_o pulse, opcode 01, wr_en 1; wb_valid_o 4 cycles after accept with prior mscratch value.
- CSRRS rs1=x0 on mcycle -> wr_en 0, opcode 10; wb_data = csr_rdata_i.
- CSRRCI zimm=5 -> csr_data_o=0x00000005, opcode 11, wr_en 1.
- Tag 7, head=3 for 10 cycles then 7 -> no csr_valid_o until head matches; flush in WAIT_HEAD -> no request, IDLE, ready=1.
- csr_excp_i=1 (user write to MSTATUS) -> wb_excp_o=1, wb_data_o=0; flush during WAIT_DONE -> wb_valid_o stays 0, return to IDLE after done.
